// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit framer.
//   - tx_state_e  : framer FSM states (PARITY exists only when the
//                   UART_TX_PARITY_EN macro is defined)
//   - line levels : TX_IDLE_LVL, START_BIT, STOP_BIT
//   - parity type : PAR_EVEN, PAR_ODD
//   - parity_bit(): turns an XOR-reduced payload into the transmitted bit
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam logic TX_IDLE_LVL = 1'b1;
    localparam logic START_BIT   = 1'b0;
    localparam logic STOP_BIT    = 1'b1;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Explicit encodings keep STOP at the same code whether or not PARITY
    // is compiled in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } tx_state_e;

    // Even parity transmits the XOR of the payload; odd parity transmits
    // its inverse so the total count of ones (payload + parity) is odd.
    function automatic logic parity_bit(input logic data_xor, input logic par_typ);
        return (par_typ == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// ----------------------------------------------------------------------------
// uart_tx_serializer
// Payload shift register and bit counter for the UART framer.
// Ports:
//   CLK, RST  : clock, asynchronous active-low reset
//   load      : capture data, clear counter and done
//   data      : parallel payload (DATA_WIDTH bits)
//   shift     : bit_out is being consumed; advance to the next bit
//   bit_out   : next payload bit to place on the line (LSB first)
//   done      : the last payload bit has been handed out; the counter
//               has already wrapped back to 0
// ----------------------------------------------------------------------------
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  shift,
    output logic                  bit_out,
    output logic                  done
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      cnt;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shreg <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else if (load) begin
            shreg <= data;
            cnt   <= '0;
            done  <= 1'b0;
        end else if (shift) begin
            shreg <= shreg >> 1;
            if (cnt == LAST) begin
                cnt  <= '0;
                done <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                done <= 1'b0;
            end
        end
    end

    assign bit_out = shreg[0];

endmodule

// File: rtl/uart_tx_framer.sv
// ----------------------------------------------------------------------------
// uart_tx_framer
// UART transmit framer: START bit, DATA_WIDTH payload bits LSB first,
// optional parity bit, one STOP bit. TX_OUT and Busy are registered.
// A request arriving during STOP starts the next frame with no idle gap;
// requests during START/DATA/PARITY are ignored.
// Build option: define UART_TX_PARITY_EN to include the parity bit
// (PAR_EN / PAR_TYP); without it both inputs are ignored.
// Ports:
//   CLK        : bit clock, one serial bit per rising edge
//   RST        : asynchronous active-low reset
//   P_DATA     : payload to send (DATA_WIDTH bits)
//   Data_Valid : single-cycle send request
//   PAR_EN     : insert parity bit when 1
//   PAR_TYP    : 0 even, 1 odd parity
//   TX_OUT     : serial line, idles high
//   Busy       : high while a frame occupies the line
// ----------------------------------------------------------------------------
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    tx_state_e state, state_nx;
    logic      tx_nx, busy_nx;
    logic      ser_load, ser_shift, ser_bit, ser_done;

    uart_tx_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_serializer (
        .CLK     (CLK),
        .RST     (RST),
        .load    (ser_load),
        .data    (P_DATA),
        .shift   (ser_shift),
        .bit_out (ser_bit),
        .done    (ser_done)
    );

`ifdef UART_TX_PARITY_EN
    // The shift register is consumed as the frame goes out, so parity works
    // from a separate copy of the payload captured at the same edge.
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q, par_typ_q, par_bit;

    // NOTE: these are plain control/data registers, so they get a reset
    // value; only true memory arrays are left unreset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
        end else if (ser_load) begin
            data_q    <= P_DATA;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
        end
    end

    assign par_bit = parity_bit(^data_q, par_typ_q);
`else
    logic unused_par_cfg;
    assign unused_par_cfg = PAR_EN ^ PAR_TYP;
`endif

    // The combinational block computes the value each output takes after the
    // coming edge, so TX_OUT and Busy leave the flops with no output decode.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx  = state;
        tx_nx     = TX_IDLE_LVL;
        busy_nx   = 1'b1;
        ser_load  = 1'b0;
        ser_shift = 1'b0;
        case (state)
            IDLE, STOP: begin
                if (Data_Valid) begin
                    state_nx = START;
                    tx_nx    = START_BIT;
                    ser_load = 1'b1;
                end else begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                end
            end
            START: begin
                state_nx  = DATA;
                tx_nx     = ser_bit;
                ser_shift = 1'b1;
            end
            DATA: begin
                if (!ser_done) begin
                    tx_nx     = ser_bit;
                    ser_shift = 1'b1;
                end
`ifdef UART_TX_PARITY_EN
                else if (par_en_q) begin
                    state_nx = PARITY;
                    tx_nx    = par_bit;
                end
`endif
                else begin
                    state_nx = STOP;
                    tx_nx    = STOP_BIT;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                state_nx = STOP;
                tx_nx    = STOP_BIT;
            end
`endif
            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= IDLE;
            TX_OUT <= TX_IDLE_LVL;
            Busy   <= 1'b0;
        end else begin
            state  <= state_nx;
            TX_OUT <= tx_nx;
            Busy   <= busy_nx;
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_framer
// Directed bench for uart_tx_framer. A frame-level model turns each accepted
// request into the list of line bits it must produce; the line and Busy are
// compared against it every cycle, and literal frame captures pin the model.
// Honours UART_TX_PARITY_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_uart_tx_framer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       TX_OUT;
    logic       Busy;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_framer #(
        .DATA_WIDTH(8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    // Frame model: line_q holds the bits still to appear on the line. A
    // request is taken only when nothing is left queued, i.e. the line is
    // idle or showing the final stop bit.
    logic line_q[$];
    logic exp_tx   = 1'b1;
    logic exp_busy = 1'b0;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            line_q.delete();
            exp_tx   <= 1'b1;
            exp_busy <= 1'b0;
        end else begin
            if (Data_Valid && line_q.size() == 0) begin
                line_q.push_back(1'b0);
                for (int i = 0; i < 8; i++) line_q.push_back(P_DATA[i]);
`ifdef UART_TX_PARITY_EN
                if (PAR_EN) line_q.push_back(^{P_DATA, PAR_TYP});
`endif
                line_q.push_back(1'b1);
            end
            if (line_q.size() != 0) begin
                exp_tx   <= line_q.pop_front();
                exp_busy <= 1'b1;
            end else begin
                exp_tx   <= 1'b1;
                exp_busy <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare the line against the model.
    task automatic tick();
        @(negedge CLK);
        check("line_tx", {31'd0, TX_OUT}, {31'd0, exp_tx});
        check("line_busy", {31'd0, Busy}, {31'd0, exp_busy});
    endtask

    // Present a one-cycle request; returns on the edge where the start bit shows.
    task automatic pulse(input logic [7:0] d, input logic pe, input logic pt);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
    endtask

    // Record line bits while Busy is high (up to max_n), scrambling the
    // parallel inputs every cycle; stops on the edge of the last bit taken
    // when max_n is reached, otherwise on the first idle edge.
    task automatic capture(input int max_n, output logic [31:0] bits, output int n);
        bits = '0;
        n    = 0;
        for (int i = 0; i < 64; i++) begin
            if (!Busy) break;
            bits = {bits[30:0], TX_OUT};
            n++;
            if (n == max_n) break;
            P_DATA  = ~P_DATA;
            PAR_EN  = ~PAR_EN;
            PAR_TYP = ~PAR_TYP;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b1, b2;
        int          n1, n2;

        // Reset state
        tick();
        tick();
        check("reset_tx", {31'd0, TX_OUT}, 32'd1);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        RST = 1'b1;
        tick();
        tick();

        // 0xA5 without parity: 0,1,0,1,0,0,1,0,1,1
        pulse(8'hA5, 1'b0, 1'b0);
        capture(64, b1, n1);
        check("a5_len", n1, 32'd10);
        check("a5_bits", b1, 32'b0101001011);
        tick();

`ifdef UART_TX_PARITY_EN
        // 0xA5 has four ones: even parity bit 0, odd parity bit 1
        pulse(8'hA5, 1'b1, 1'b0);
        capture(64, b1, n1);
        check("a5_even_len", n1, 32'd11);
        check("a5_even_bits", b1, 32'b01010010101);
        tick();
        pulse(8'hA5, 1'b1, 1'b1);
        capture(64, b1, n1);
        check("a5_odd_len", n1, 32'd11);
        check("a5_odd_bits", b1, 32'b01010010111);
        tick();
`endif

        // 0x0F with PAR_EN=1, even parity
        pulse(8'h0F, 1'b1, 1'b0);
        capture(64, b1, n1);
`ifdef UART_TX_PARITY_EN
        check("0f_len", n1, 32'd11);
        check("0f_bits", b1, 32'b01111000001);
`else
        check("0f_len", n1, 32'd10);
        check("0f_bits", b1, 32'b0111100001);
`endif
        tick();

        // 0x00 then 0xFF requested during the stop bit: 20 contiguous cycles
        pulse(8'h00, 1'b0, 1'b0);
        capture(10, b1, n1);
        check("b2b_stop_shown", {31'd0, TX_OUT}, 32'd1);
        pulse(8'hFF, 1'b0, 1'b0);
        capture(64, b2, n2);
        check("b2b_len", n1 + n2, 32'd20);
        check("b2b_bits", (b1 << n2) | b2, 32'b0000000001_0111111111);
        tick();

        // 0x3C requested while bit 3 of an 0x81 frame is on the line
        pulse(8'h81, 1'b0, 1'b0);
        capture(5, b1, n1);
        pulse(8'h3C, 1'b0, 1'b0);
        capture(64, b2, n2);
        check("ign_len", n1 + n2, 32'd10);
        check("ign_bits", (b1 << n2) | b2, 32'b0100000011);
        tick();
        check("ign_idle_tx", {31'd0, TX_OUT}, 32'd1);
        check("ign_idle_busy", {31'd0, Busy}, 32'd0);

        // Reset while data bit 4 (a 0) of 0xEF is on the line
        pulse(8'hEF, 1'b0, 1'b0);
        capture(6, b1, n1);
        check("rst_pre_bits", b1, 32'b011110);
        #2 RST = 1'b0;
        #1;
        check("rst_mid_tx", {31'd0, TX_OUT}, 32'd1);
        check("rst_mid_busy", {31'd0, Busy}, 32'd0);
        tick();
        tick();
        RST = 1'b1;
        tick();
        pulse(8'h55, 1'b0, 1'b0);
        capture(64, b1, n1);
        check("post_rst_len", n1, 32'd10);
        check("post_rst_bits", b1, 32'b0101010101);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
